// File: rtl/timer_dev_if.sv
// Peripheral bus seen by the countdown timer: register select, write strobe,
// write data and combinational read data.
interface timer_dev_if;
    logic [1:0]  Addr;
    logic        We;
    logic [31:0] Din;
    logic [31:0] Dout;

    // Bridge side drives the request and reads the data back.
    modport master (
        output Addr,
        output We,
        output Din,
        input  Dout
    );

    // Timer side consumes the request and returns read data.
    modport slave (
        input  Addr,
        input  We,
        input  Din,
        output Dout
    );
endinterface

// File: rtl/timer_dev.sv
// Memory-mapped countdown timer. CTRL = {IM, Mode[1:0], Enable}, PRESET is
// the reload value, and COUNT is the read-only live counter. Mode 1 reloads
// automatically and pulses the interrupt for one cycle. Any other mode is
// one-shot: the timer clears Enable and holds the interrupt until CTRL is
// written.
module timer_dev #(
    parameter int COUNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    timer_dev_if.slave  bus,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    state_t               state_r;
    state_t               state_next_s;
    logic [3:0]           ctrl_r;
    logic [3:0]           ctrl_next_s;
    logic [COUNT_W-1:0]   preset_r;
    logic [COUNT_W-1:0]   preset_next_s;
    logic [COUNT_W-1:0]   count_r;
    logic [COUNT_W-1:0]   count_next_s;
    logic                 irq_flag_r;
    logic                 irq_flag_next_s;
    logic                 irq_r;
    logic [31:0]          dout_s;

    // State and register update; reset returns everything to zero even if a write is present.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            ctrl_r     <= 4'd0;
            preset_r   <= '0;
            count_r    <= '0;
            irq_flag_r <= 1'b0;
            irq_r      <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            ctrl_r     <= ctrl_next_s;
            preset_r   <= preset_next_s;
            count_r    <= count_next_s;
            irq_flag_r <= irq_flag_next_s;
            irq_r      <= irq_flag_next_s & ctrl_next_s[3];
        end
    end

    // Timer sequencing first, then the bus write; the write overrides CTRL and irq_flag.
    always_comb begin
        state_next_s    = state_r;
        ctrl_next_s     = ctrl_r;
        preset_next_s   = preset_r;
        count_next_s    = count_r;
        irq_flag_next_s = irq_flag_r;

        case (state_r)
            ST_IDLE: begin
                if (ctrl_r[0]) begin
                    state_next_s = ST_LOAD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                count_next_s = preset_r;
                state_next_s = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl_r[0]) begin
                    state_next_s = ST_IDLE;
                end else if (count_r > COUNT_W'(1)) begin
                    count_next_s = count_r - COUNT_W'(1);
                end else begin
                    // Treat 0 like 1 so that PRESET=0 never wraps.
                    count_next_s    = '0;
                    irq_flag_next_s = 1'b1;
                    state_next_s    = ST_INT;
                end
            end
            ST_INT: begin
                if (ctrl_r[2:1] == 2'd1) begin
                    irq_flag_next_s = 1'b0;
                    state_next_s    = ST_LOAD;
                end else begin
                    ctrl_next_s[0] = 1'b0;
                    state_next_s   = ST_IDLE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase

        // A PRESET write only changes the reload value; a running count keeps going.
        case ({bus.We, bus.Addr})
            3'b100: begin
                ctrl_next_s     = bus.Din[3:0];
                irq_flag_next_s = 1'b0;
            end
            3'b101: begin
                preset_next_s = bus.Din[COUNT_W-1:0];
            end
            default: begin
                preset_next_s = preset_next_s;
            end
        endcase
    end

    // Zero-latency read mux; unused high bits read as zero.
    always_comb begin
        dout_s = 32'd0;
        case (bus.Addr)
            2'd0:    dout_s[3:0]         = ctrl_r;
            2'd1:    dout_s[COUNT_W-1:0] = preset_r;
            2'd2:    dout_s[COUNT_W-1:0] = count_r;
            default: dout_s              = 32'd0;
        endcase
    end

    assign bus.Dout = dout_s;
    assign IRQ      = irq_r;

endmodule

// File: tb/tb_timer_dev.sv
// Directed bench for timer_dev. Stimulus pushes the expected read data and
// IRQ into a scoreboard queue and raises rd_req. A monitor pops the queue at
// the falling edge and compares against the DUT.
module tb_timer_dev;

    typedef struct {
        string       name;
        logic [31:0] exp_dout;
        logic        exp_irq;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        irq;
    logic        rd_req;
    int          checks;
    int          failures;
    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [31:0] ar_cnt [0:4];

    timer_dev_if bus();

    timer_dev #(.COUNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .IRQ   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so that the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1);
    end

    // Monitor: compare the DUT against the oldest expectation whenever a read is presented.
    always @(negedge clk) begin
        if (rd_req) begin
            if (sb_q.size() == 0) begin
                checks   = checks + 1;
                failures = failures + 1;
                $display("FAIL scoreboard_empty: read presented with no expectation");
            end else begin
                mon_e  = sb_q.pop_front();
                checks = checks + 1;
                if (bus.Dout !== mon_e.exp_dout) begin
                    failures = failures + 1;
                    $display("FAIL %s dout: got %h expected %h", mon_e.name, bus.Dout, mon_e.exp_dout);
                end
                checks = checks + 1;
                if (irq !== mon_e.exp_irq) begin
                    failures = failures + 1;
                    $display("FAIL %s irq: got %b expected %b", mon_e.name, irq, mon_e.exp_irq);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
        bus.Addr = addr;
        bus.We   = 1'b1;
        bus.Din  = data;
        @(posedge clk);
        #1;
        bus.We   = 1'b0;
        bus.Din  = 32'd0;
    endtask

    task automatic check(input logic [1:0] addr, input logic [31:0] exp_dout,
                         input logic exp_irq, input string name);
        exp_t e;
        e.name     = name;
        e.exp_dout = exp_dout;
        e.exp_irq  = exp_irq;
        bus.Addr   = addr;
        sb_q.push_back(e);
        rd_req = 1'b1;
        @(negedge clk);
        #1;
        rd_req = 1'b0;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rd_req    = 1'b0;
        ar_cnt[0] = 32'd0;
        ar_cnt[1] = 32'd0;
        ar_cnt[2] = 32'd3;
        ar_cnt[3] = 32'd2;
        ar_cnt[4] = 32'd1;

        // Reset for 2 cycles while a write is attempted.
        reset    = 1'b1;
        bus.Addr = 2'd0;
        bus.We   = 1'b1;
        bus.Din  = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        #1;
        reset   = 1'b0;
        bus.We  = 1'b0;
        bus.Din = 32'd0;
        check(2'd0, 32'd0, 1'b0, "rst_ctrl");
        check(2'd1, 32'd0, 1'b0, "rst_preset");
        check(2'd2, 32'd0, 1'b0, "rst_count");
        check(2'd3, 32'd0, 1'b0, "rst_rsvd");

        // One-shot, PRESET=5.
        bus_write(2'd1, 32'd5);
        bus_write(2'd0, 32'h9);               // edge 0
        tick();                               // edge 1 (LOAD)
        for (int e = 2; e <= 6; e++) begin
            tick();
            check(2'd2, 32'(7 - e), 1'b0, "os_count");
        end
        tick();                               // edge 7
        check(2'd2, 32'd0, 1'b1, "os_irq_rise");
        tick();                               // edge 8
        check(2'd0, 32'h8, 1'b1, "os_en_cleared");
        repeat (3) tick();
        check(2'd0, 32'h8, 1'b1, "os_irq_held");
        bus_write(2'd0, 32'h8);
        check(2'd0, 32'h8, 1'b0, "os_irq_cleared");

        // Auto-reload, PRESET=3: IRQ every 5 cycles.
        bus_write(2'd1, 32'd3);
        bus_write(2'd0, 32'hB);               // edge 0
        for (int e = 1; e <= 20; e++) begin
            tick();
            check(2'd2, ar_cnt[e % 5], ((e % 5) == 0), "ar_period");
        end
        bus_write(2'd0, 32'h0);
        repeat (3) tick();

        // Masked interrupt, PRESET=2.
        bus_write(2'd1, 32'd2);
        bus_write(2'd0, 32'h1);               // edge 0
        for (int e = 1; e <= 6; e++) begin
            tick();
            check(2'd0, (e <= 4) ? 32'h1 : 32'h0, 1'b0, "mask_irq_low");
        end
        bus_write(2'd0, 32'h8);
        check(2'd0, 32'h8, 1'b0, "mask_flag_cleared");
        tick();
        check(2'd0, 32'h8, 1'b0, "mask_flag_stays_clear");
        bus_write(2'd0, 32'h0);

        // Pause at COUNT=7 and resume from PRESET, with writes to COUNT/reserved ignored.
        bus_write(2'd1, 32'd10);
        bus_write(2'd0, 32'h9);               // edge 0
        repeat (4) tick();                    // edge 4
        check(2'd2, 32'd8, 1'b0, "pr_count8");
        bus_write(2'd0, 32'h8);               // edge 5: COUNT=7, Enable off
        check(2'd2, 32'd7, 1'b0, "pr_count7");
        bus_write(2'd2, 32'h0000_0055);
        check(2'd2, 32'd7, 1'b0, "count_write_ignored");
        bus_write(2'd3, 32'h0000_00AA);
        check(2'd3, 32'd0, 1'b0, "rsvd_reads_zero");
        for (int i = 0; i < 10; i++) begin
            tick();
            check(2'd2, 32'd7, 1'b0, "pr_hold");
        end
        bus_write(2'd0, 32'h9);               // edge R
        tick();                               // edge R+1 (LOAD)
        check(2'd2, 32'd7, 1'b0, "pr_load_pending");
        tick();                               // edge R+2
        check(2'd2, 32'd10, 1'b0, "pr_restart");
        tick();
        check(2'd2, 32'd9, 1'b0, "pr_resume_dec");
        bus_write(2'd0, 32'h0);
        repeat (3) tick();

        // PRESET=0 behaves as 1: IRQ at edge 3.
        bus_write(2'd1, 32'd0);
        bus_write(2'd0, 32'h9);               // edge 0
        tick();
        check(2'd0, 32'h9, 1'b0, "p0_edge1");
        tick();
        check(2'd2, 32'd0, 1'b0, "p0_edge2");
        tick();
        check(2'd2, 32'd0, 1'b1, "p0_irq_edge3");
        bus_write(2'd0, 32'h0);
        repeat (2) tick();

        // CTRL write collides with the flag being set, then with the Enable clear in INT.
        bus_write(2'd1, 32'd2);
        bus_write(2'd0, 32'h9);               // edge 0
        repeat (3) tick();                    // edge 3, COUNT=1
        bus_write(2'd0, 32'h9);               // edge 4
        check(2'd2, 32'd0, 1'b0, "sim_write_clear_wins");
        bus_write(2'd0, 32'hB);               // edge 5, INT
        check(2'd0, 32'hB, 1'b0, "sim_ctrl_write_wins");
        bus_write(2'd0, 32'h0);
        repeat (3) tick();

        // PRESET written in the LOAD cycle: COUNT takes the old value.
        bus_write(2'd1, 32'd4);
        bus_write(2'd0, 32'h1);               // edge 0
        tick();                               // edge 1 (LOAD)
        bus_write(2'd1, 32'd9);               // edge 2
        check(2'd2, 32'd4, 1'b0, "ld_old_preset");
        tick();
        check(2'd1, 32'd9, 1'b0, "ld_new_preset");
        bus_write(2'd0, 32'h0);
        repeat (3) tick();

        // Reset asserted mid-count while a write is attempted.
        bus_write(2'd1, 32'd6);
        bus_write(2'd0, 32'h9);               // edge 0
        repeat (4) tick();                    // edge 4
        check(2'd2, 32'd4, 1'b0, "rm_count4");
        reset    = 1'b1;
        bus.We   = 1'b1;
        bus.Addr = 2'd1;
        bus.Din  = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        bus.We  = 1'b0;
        bus.Din = 32'd0;
        check(2'd2, 32'd0, 1'b0, "rm_count");
        check(2'd0, 32'd0, 1'b0, "rm_ctrl");
        check(2'd1, 32'd0, 1'b0, "rm_preset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
